// File: rtl/ram_stream_pkg.sv
// Shared types and constants for the scratchpad wide-port row streamer.
package ram_stream_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam int unsigned STREAM_BUF_DEPTH = 2;
  localparam int unsigned STREAM_BUF_CNT_W = $clog2(STREAM_BUF_DEPTH + 1);

endpackage

// File: rtl/stream_buf2.sv
// Two-entry synchronous FIFO for stream stages; push and pop may coincide even when full.
module stream_buf2
  import ram_stream_pkg::*;
#(
  parameter int unsigned width = 256
) (
  input  logic                        clk,
  input  logic                        nrst,
  input  logic                        clr,
  input  logic                        push,
  input  logic [width-1:0]            din,
  input  logic                        pop,
  output logic [width-1:0]            dout,
  output logic [STREAM_BUF_CNT_W-1:0] count,
  output logic                        empty,
  output logic                        full
);

  logic [width-1:0] mem [STREAM_BUF_DEPTH];
  logic             wr_ptr;
  logic             rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == STREAM_BUF_CNT_W'(STREAM_BUF_DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  // When full with a coincident pop, the write lands in the slot being vacated.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int unsigned i = 0; i < STREAM_BUF_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + STREAM_BUF_CNT_W'(1);
        2'b01:   count <= count - STREAM_BUF_CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ram_row_streamer.sv
// Issues strided wide-port RAM reads and streams the returned rows out as valid/ready.
module ram_row_streamer
  import ram_stream_pkg::*;
#(
  parameter int unsigned addrWidth = 32,
  parameter int unsigned rowWidth  = 256,
  parameter int unsigned cntWidth  = 16
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic [addrWidth-1:0] base_addr_i,
  input  logic [cntWidth-1:0]  num_rows_i,
  input  logic [cntWidth-1:0]  stride_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 rd_en_o,
  output logic [addrWidth-1:0] rd_addr_o,
  input  logic [rowWidth-1:0]  rd_data_i,
  output logic [rowWidth-1:0]  data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 last_o
);

  localparam int unsigned USED_W = STREAM_BUF_CNT_W + 1;

  state_e                      state_q;
  state_e                      state_d;
  logic [addrWidth-1:0]        addr_q;
  logic [cntWidth-1:0]         num_rows_q;
  logic [cntWidth-1:0]         stride_q;
  logic [cntWidth-1:0]         issued_q;
  logic [cntWidth-1:0]         delivered_q;
  logic                        inflight_q;
  logic [STREAM_BUF_CNT_W-1:0] occ;
  logic                        buf_empty;
  logic                        buf_full;
  logic                        buf_clr;
  logic                        buf_push;
  logic                        pop;
  logic [USED_W-1:0]           used;
  logic                        issue_room;
  logic                        final_issue;
  logic                        launch;

  assign launch      = (state_q == S_IDLE) & start_i;
  assign valid_o     = ~buf_empty;
  assign pop         = valid_o & ready_i;
  assign last_o      = valid_o & (delivered_q == num_rows_q - cntWidth'(1));
  assign rd_addr_o   = addr_q;
  assign buf_clr     = abort_i & (state_q != S_IDLE);
  assign buf_push    = inflight_q & ~abort_i;
  assign final_issue = rd_en_o & (issued_q == num_rows_q - cntWidth'(1));

  // Buffer slots plus the read in flight must not exceed two unless a pop frees one now.
  assign used       = USED_W'(occ) + USED_W'(inflight_q);
  assign issue_room = buf_full ? (~inflight_q & pop)
                               : ((used < USED_W'(STREAM_BUF_DEPTH)) |
                                  ((used == USED_W'(STREAM_BUF_DEPTH)) & pop));

  stream_buf2 #(.width(rowWidth)) u_buf (
    .clk   (clk),
    .nrst  (nrst),
    .clr   (buf_clr),
    .push  (buf_push),
    .din   (rd_data_i),
    .pop   (pop),
    .dout  (data_o),
    .count (occ),
    .empty (buf_empty),
    .full  (buf_full)
  );

  // State register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; abort outranks everything outside IDLE.
  always_comb begin
    state_d = state_q;
    if (abort_i && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (start_i) state_d = (num_rows_i == '0) ? S_DONE : S_RUN;
        S_RUN:   if (final_issue) state_d = S_DRAIN;
        S_DRAIN: if (pop && last_o) state_d = S_DONE;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // FSM outputs; rd_en_o sees ready_i through the pop term.
  always_comb begin
    busy_o  = 1'b0;
    done_o  = 1'b0;
    rd_en_o = 1'b0;
    busy_o  = (state_q != S_IDLE);
    done_o  = (state_q == S_DONE);
    rd_en_o = (state_q == S_RUN) & ~abort_i & (issued_q < num_rows_q) & issue_room;
  end

  // Job parameters, counters, running address and in-flight flag.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      addr_q      <= '0;
      num_rows_q  <= '0;
      stride_q    <= '0;
      issued_q    <= '0;
      delivered_q <= '0;
      inflight_q  <= 1'b0;
    end else if (launch) begin
      addr_q      <= base_addr_i;
      num_rows_q  <= num_rows_i;
      stride_q    <= stride_i;
      issued_q    <= '0;
      delivered_q <= '0;
      inflight_q  <= 1'b0;
    end else begin
      inflight_q <= rd_en_o;
      if (rd_en_o) begin
        addr_q   <= addr_q + addrWidth'(stride_q);
        issued_q <= issued_q + cntWidth'(1);
      end
      if (pop) delivered_q <= delivered_q + cntWidth'(1);
    end
  end

endmodule

// File: tb/tb_ram_row_streamer.sv
// Directed and randomized jobs against a RAM model and an address/row scoreboard.
module tb_ram_row_streamer;

  localparam int unsigned AW = 32;
  localparam int unsigned RW = 256;
  localparam int unsigned CW = 16;

  logic          clk;
  logic          nrst;
  logic          start_i;
  logic          abort_i;
  logic [AW-1:0] base_addr_i;
  logic [CW-1:0] num_rows_i;
  logic [CW-1:0] stride_i;
  logic          busy_o;
  logic          done_o;
  logic          rd_en_o;
  logic [AW-1:0] rd_addr_o;
  logic [RW-1:0] rd_data_i;
  logic [RW-1:0] data_o;
  logic          valid_o;
  logic          ready_i;
  logic          last_o;

  int          checks;
  int          errors;
  logic [31:0] salt;

  ram_row_streamer #(.addrWidth(AW), .rowWidth(RW), .cntWidth(CW)) dut (
    .clk         (clk),
    .nrst        (nrst),
    .start_i     (start_i),
    .abort_i     (abort_i),
    .base_addr_i (base_addr_i),
    .num_rows_i  (num_rows_i),
    .stride_i    (stride_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .rd_en_o     (rd_en_o),
    .rd_addr_o   (rd_addr_o),
    .rd_data_i   (rd_data_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .last_o      (last_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Row contents are a hash of the address so every row is distinct.
  function automatic logic [RW-1:0] row_of(input logic [AW-1:0] a);
    logic [RW-1:0] r;
    r = '0;
    for (int i = 0; i < int'(RW / 32); i++)
      r[i*32 +: 32] = (a * 32'h9E37_79B1) ^ salt ^ {8'(i), 24'h5A_5A5A};
    return r;
  endfunction

  // One-cycle-latency RAM; garbage on the bus when not reading.
  always @(posedge clk) begin
    if (rd_en_o) rd_data_i <= row_of(rd_addr_o);
    else         rd_data_i <= {8{32'($urandom)}};
  end

  task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"},    RW'(busy_o),    RW'(0));
    chk({tag, "_done"},    RW'(done_o),    RW'(0));
    chk({tag, "_rd_en"},   RW'(rd_en_o),   RW'(0));
    chk({tag, "_rd_addr"}, RW'(rd_addr_o), RW'(0));
    chk({tag, "_valid"},   RW'(valid_o),   RW'(0));
    chk({tag, "_last"},    RW'(last_o),    RW'(0));
    chk({tag, "_data"},    data_o,         RW'(0));
  endtask

  task automatic drive_idle();
    start_i = 1'b0;
    abort_i = 1'b0;
    ready_i = 1'b1;
  endtask

  // rmode: 0 ready held high, 1 ready pattern 1,0,0, 2 random ready.
  task automatic run_job(input logic [AW-1:0] base, input logic [CW-1:0] stride, input int rows,
                         input int rmode, input int abort_at, input int rst_at, input bit timed);
    logic [AW-1:0] exp_addr[$];
    logic [RW-1:0] held;
    int            n_iss;
    int            n_del;
    int            done_c;
    int            bound;
    bit            stall;
    bit            ended;
    bit            was_reset;
    exp_addr  = {};
    salt      = $urandom;
    for (int i = 0; i < rows; i++) exp_addr.push_back(base + AW'(i) * AW'(stride));
    n_iss     = 0;
    n_del     = 0;
    done_c    = -1;
    stall     = 1'b0;
    ended     = 1'b0;
    was_reset = 1'b0;
    held      = '0;
    bound     = 24 * rows + 24;
    for (int c = 0; c < bound && !ended; c++) begin
      @(negedge clk);
      start_i     = (c == 0) || (c == 2 && rows > 0);
      base_addr_i = (c == 0) ? base : 32'h1234_0000;
      num_rows_i  = (c == 0) ? CW'(rows) : 16'd3;
      stride_i    = (c == 0) ? stride : 16'd4;
      abort_i     = (c == abort_at);
      case (rmode)
        0:       ready_i = 1'b1;
        1:       ready_i = (c % 3 == 0);
        default: ready_i = ($urandom_range(0, 3) != 0);
      endcase
      if (c == rst_at) nrst = 1'b0;
      #1;
      if (c == rst_at) begin
        check_idle_outputs("mid_job_reset");
        was_reset = 1'b1;
        ended     = 1'b1;
      end else begin
        if (c == 2 && rows > 0) chk("busy_ignores_start", RW'(busy_o), RW'(1));
        chk("occupancy_bound", RW'(n_iss - n_del <= 2), RW'(1));
        if (timed) begin
          chk("rd_en_timing", RW'(rd_en_o), RW'(c >= 1 && c <= rows));
          chk("valid_timing", RW'(valid_o), RW'(c >= 3 && c <= rows + 2));
          chk("done_timing", RW'(done_o), RW'(c == ((rows == 0) ? 1 : rows + 3)));
        end
        if (c == abort_at) chk("abort_blocks_issue", RW'(rd_en_o), RW'(0));
        if (rd_en_o) begin
          chk("issue_count", RW'(n_iss < rows), RW'(1));
          if (n_iss < rows) chk("rd_addr", RW'(rd_addr_o), RW'(exp_addr[n_iss]));
          n_iss++;
        end
        if (stall) begin
          chk("valid_held", RW'(valid_o), RW'(1));
          chk("data_held", data_o, held);
        end
        if (valid_o) begin
          chk("row_count", RW'(n_del < rows), RW'(1));
          if (n_del < rows) begin
            chk("row_data", data_o, row_of(exp_addr[n_del]));
            chk("last", RW'(last_o), RW'(n_del == rows - 1));
          end
        end else begin
          chk("last_without_valid", RW'(last_o), RW'(0));
        end
        stall = valid_o && !ready_i && (c != abort_at);
        held  = data_o;
        if (valid_o && ready_i && c != abort_at) n_del++;
        if (done_o) begin
          chk("done_after_all_rows", RW'(n_del), RW'(rows));
          done_c = c;
          ended  = 1'b1;
        end
        if (c == abort_at) ended = 1'b1;
      end
    end
    if (was_reset) begin
      @(negedge clk);
      nrst = 1'b1;
      drive_idle();
      for (int k = 0; k < 3; k++) begin
        #1;
        chk("post_reset_valid", RW'(valid_o), RW'(0));
        chk("post_reset_busy", RW'(busy_o), RW'(0));
        @(negedge clk);
      end
    end else if (abort_at >= 0) begin
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        drive_idle();
        #1;
        chk("post_abort_busy", RW'(busy_o), RW'(0));
        chk("post_abort_valid", RW'(valid_o), RW'(0));
        chk("post_abort_done", RW'(done_o), RW'(0));
        chk("post_abort_rd_en", RW'(rd_en_o), RW'(0));
      end
    end else begin
      chk("job_completed", RW'(done_c >= 0), RW'(1));
      chk("rows_delivered", RW'(n_del), RW'(rows));
      chk("reads_issued", RW'(n_iss), RW'(rows));
      @(negedge clk);
      drive_idle();
      #1;
      chk("idle_after_done", RW'(busy_o), RW'(0));
      chk("done_single_cycle", RW'(done_o), RW'(0));
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    nrst        = 1'b0;
    start_i     = 1'b0;
    abort_i     = 1'b0;
    ready_i     = 1'b0;
    base_addr_i = '0;
    num_rows_i  = '0;
    stride_i    = '0;
    salt        = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    check_idle_outputs("reset");
    @(negedge clk);
    nrst = 1'b1;

    run_job(32'h0000_0040, 16'd32, 4, 0, -1, -1, 1'b1);
    run_job(32'h0000_0040, 16'd32, 4, 1, -1, -1, 1'b0);
    run_job(32'h0000_1000, 16'd64, 0, 0, -1, -1, 1'b1);
    run_job(32'hFFFF_FFE0, 16'd32, 3, 0, -1, -1, 1'b1);
    run_job(32'h0000_0200, 16'd32, 8, 0, 4, -1, 1'b0);
    run_job(32'h0000_0300, 16'd32, 2, 0, -1, -1, 1'b1);
    run_job(32'h0000_0400, 16'd32, 8, 0, -1, 5, 1'b0);
    run_job(32'h0000_0500, 16'd96, 2, 2, -1, -1, 1'b0);
    for (int k = 0; k < 6; k++)
      run_job(32'($urandom), CW'($urandom), int'($urandom_range(1, 12)), 2, -1, -1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
